io_bus_responder: RTL and testbench
===================================

// Module: io_bus_responder
// PURPOSE
// Memory-mapped I/O responder on the processor's memory bus (15-bit address,
// 8-bit data, separate read/write strobes), sitting in parallel with RAM.
// Claims a 4-byte window. Processor stores go into a TX FIFO drained by an
// external valid/ready sink. A one-entry RX buffer, filled by an external
// valid/ready source, is read back by processor loads. Status/control registers
// expose FIFO state and sticky error flags.
// PARAMETERS
// BASE_ADDR   15'h7FFC  window base; bits [1:0] must be 0
// FIFO_DEPTH  4         TX FIFO entries; power of 2, >=2
// PORTS
// clk          in   1   system clock, all state on rising edge
// rst_n        in   1   asynchronous active-low reset
// addr         in   15  bus address
// wr_data      in   8   bus write data (accumulator)
// wr_en        in   1   bus write strobe, 1-cycle pulse per store
// rd_en        in   1   bus read strobe, 1-cycle pulse per load
// rd_data      out  8   registered read data
// hit          out  1   combinational: addr[14:2]==BASE_ADDR[14:2]
// out_data     out  8   TX FIFO head
// out_valid    out  1   TX FIFO non-empty
// out_ready    in   1   sink accepts out_data when out_valid&out_ready
// in_data      in   8   RX source data
// in_valid     in   1   RX source data valid
// in_ready     out  1   = ~rx_valid
// BEHAVIOUR
// - Reset: FIFO empty (wr/rd ptrs, count = 0), rx_valid=0, rx_buf=0, sticky
//   flags=0, rd_data=0, out_valid=0, in_ready=1. Reset mid-transfer discards all.
// - Register map (offset addr[1:0]), accessed only when hit=1:
//   0 TX   W: push wr_data.  R: returns 0.
//   1 RX   R: returns rx_buf, clears rx_valid.  W: ignored.
//   2 STAT R: {3'b0, rx_underflow, tx_overflow, rx_valid, tx_empty, tx_full}. W: ignored.
//   3 CTRL W: bit0=1 clears both sticky flags; bit1=1 flushes TX FIFO. R: returns 0.
// - Read latency: rd_en sampled at edge N, rd_data valid after edge N and held
//   until next accepted read. If rd_en with hit=0, rd_data <= 0.
// - Push: wr_en & hit & offset 0. If FIFO full (pre-edge count) and no pop this
//   cycle -> data dropped, tx_overflow<=1. Full with simultaneous pop -> push
//   accepted, count unchanged.
// - Pop: out_valid & out_ready; head advances, count-1. Push to empty FIFO is
//   visible on out_valid the cycle after the edge (no fall-through).
// - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count is
//   log2(FIFO_DEPTH)+1 bits, 0..FIFO_DEPTH.
// - Flush (CTRL bit1): ptrs/count <= 0 at that edge; same-cycle pop ignored.
//   Flush and push cannot coincide (single write port).
// - RX: when in_valid & in_ready, rx_buf<=in_data, rx_valid<=1. A read of RX
//   while rx_valid=0 returns 0 and sets rx_underflow. RX read and new in_valid in
//   the same cycle: read returns the old rx_buf, rx_valid clears; the new byte is
//   taken next cycle (in_ready was 0 at this edge).
// - STAT read returns pre-edge state. A CTRL clear in the same cycle as a new
//   error event: the set wins.
// - wr_en and rd_en high together: both serviced independently.
// TESTING
// 1 Reset: rst_n=0 mid-stream -> out_valid=0, in_ready=1, STAT read = 8'h02.
// 2 Write 0x11,0x22,0x33,0x44 to 0x7FFC with out_ready=0 -> STAT=8'h01; a fifth
//   write 0x55 -> dropped, STAT=8'h09. Then out_ready=1 -> 11,22,33,44 on
//   consecutive cycles, then out_valid=0.
// 3 Full FIFO, out_ready=1 and write 0x66 in the same cycle -> no overflow;
//   drain order ends ...,44,66 (ptr wrap verified).
// 4 in_data=0xA5,in_valid=1 -> in_ready drops next cycle. Read 0x7FFD -> rd_data
//   =0xA5 one cycle later, in_ready=1. Read again -> 0x00, STAT bit4=1.
// 5 Write CTRL=8'h03 with 2 bytes queued and flags set -> STAT=8'h02, out_valid=0.
// 6 rd_en at addr 0x0100 -> hit=0, rd_data=0x00, no state change.

Source files
------------

// File: rtl/io_bus_responder.sv
// io_bus_responder: memory-mapped I/O window on the processor bus.
// Stores to the TX register are queued in a small FIFO drained by a
// valid/ready sink; a one-entry RX buffer filled by a valid/ready source
// is read back by loads. STAT/CTRL expose FIFO state and sticky errors.
module io_bus_responder #(
    parameter logic [14:0] BASE_ADDR  = 15'h7FFC,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [14:0] addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        hit,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] OFF_TX   = 2'd0;
    localparam logic [1:0] OFF_RX   = 2'd1;
    localparam logic [1:0] OFF_STAT = 2'd2;
    localparam logic [1:0] OFF_CTRL = 2'd3;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_rxBuf;
    logic          r_rxValid;
    logic          r_txOverflow;
    logic          r_rxUnderflow;
    logic [7:0]    r_rdData;

    logic [1:0]    w_offset;
    logic          w_txFull;
    logic          w_txEmpty;
    logic          w_pushReq;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_clearFlags;
    logic          w_overflowEvt;
    logic          w_rxRead;
    logic          w_underflowEvt;
    logic          w_rxAccept;
    logic [7:0]    w_stat;
    logic [7:0]    w_rdValue;

    assign hit       = (addr[14:2] == BASE_ADDR[14:2]);
    assign w_offset  = addr[1:0];
    assign w_txFull  = (r_count == FULL_COUNT);
    assign w_txEmpty = (r_count == '0);
    assign out_valid = ~w_txEmpty;
    assign out_data  = r_mem[r_rdPtr];
    assign in_ready  = ~r_rxValid;
    assign rd_data   = r_rdData;
    assign w_stat    = {3'b000, r_rxUnderflow, r_txOverflow, r_rxValid, w_txEmpty, w_txFull};

    // Bus decode: which register is touched this cycle and which events result.
    always_comb begin
        w_pushReq      = wr_en & hit & (w_offset == OFF_TX);
        w_pop          = out_valid & out_ready;
        w_push         = w_pushReq & (~w_txFull | w_pop);
        w_overflowEvt  = w_pushReq & w_txFull & ~w_pop;
        w_flush        = wr_en & hit & (w_offset == OFF_CTRL) & wr_data[1];
        w_clearFlags   = wr_en & hit & (w_offset == OFF_CTRL) & wr_data[0];
        w_rxRead       = rd_en & hit & (w_offset == OFF_RX);
        w_underflowEvt = w_rxRead & ~r_rxValid;
        w_rxAccept     = in_valid & in_ready;
    end

    // Read mux: value captured into rd_data on an accepted load.
    always_comb begin
        w_rdValue = 8'h00;
        if (hit) begin
            case (w_offset)
                OFF_RX:   w_rdValue = r_rxValid ? r_rxBuf : 8'h00;
                OFF_STAT: w_rdValue = w_stat;
                default:  w_rdValue = 8'h00;
            endcase
        end
    end

    // TX FIFO storage, pointers and occupancy; flush overrides a same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= wr_data;
                r_wrPtr        <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // One-entry RX buffer: a load of RX empties it, the source refills it when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxBuf   <= 8'h00;
            r_rxValid <= 1'b0;
        end else if (w_rxAccept) begin
            r_rxBuf   <= in_data;
            r_rxValid <= 1'b1;
        end else if (w_rxRead) begin
            r_rxValid <= 1'b0;
        end
    end

    // Sticky error flags; a new error event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txOverflow  <= 1'b0;
            r_rxUnderflow <= 1'b0;
        end else begin
            if (w_overflowEvt) begin
                r_txOverflow <= 1'b1;
            end else if (w_clearFlags) begin
                r_txOverflow <= 1'b0;
            end
            if (w_underflowEvt) begin
                r_rxUnderflow <= 1'b1;
            end else if (w_clearFlags) begin
                r_rxUnderflow <= 1'b0;
            end
        end
    end

    // Registered read data, held until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdData <= 8'h00;
        end else if (rd_en) begin
            r_rdData <= w_rdValue;
        end
    end

endmodule

// File: tb/tb_io_bus_responder.sv
// Testbench for io_bus_responder: directed bus stores/loads with a scoreboard
// of expected TX bytes (checked as the sink takes them) and expected load data.
module tb_io_bus_responder;

    logic        clk;
    logic        rst_n;
    logic [14:0] addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        hit;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] txQ[$];
    logic [7:0] rdQ[$];

    localparam logic [14:0] ADDR_TX   = 15'h7FFC;
    localparam logic [14:0] ADDR_RX   = 15'h7FFD;
    localparam logic [14:0] ADDR_STAT = 15'h7FFE;
    localparam logic [14:0] ADDR_CTRL = 15'h7FFF;

    io_bus_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .hit       (hit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One compare point: count it, and report it if it does not hold.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive one bus cycle with the given strobes, then release them.
    task automatic applyStimulus(input logic w, input logic r, input logic [14:0] a, input logic [7:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = w;
        rd_en   = r;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
    endtask

    // Store; bytes the FIFO should accept go onto the TX scoreboard.
    task automatic busWrite(input logic [14:0] a, input logic [7:0] d, input bit accepted);
        if (accepted) txQ.push_back(d);
        applyStimulus(1'b1, 1'b0, a, d);
    endtask

    // Load; rd_data is checked one edge later against the expected value.
    task automatic busRead(input string tag, input logic [14:0] a, input logic [7:0] expected);
        rdQ.push_back(expected);
        applyStimulus(1'b0, 1'b1, a, 8'h00);
        checkOutput(tag, rd_data, rdQ.pop_front());
    endtask

    // Sink side of the scoreboard: every byte handed over must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (txQ.size() == 0) begin
                assertCount++;
                failCount++;
                $error("[TB] FAIL tx_extra: observed %h expected none", out_data);
            end else begin
                checkOutput("tx_data", out_data, txQ.pop_front());
            end
        end
    end

    // Directed test sequence.
    initial begin
        rst_n     = 1'b0;
        addr      = 15'h0000;
        wr_data   = 8'h00;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        // Reset in the middle of traffic discards everything.
        $display("[TB] reset mid-stream");
        busWrite(ADDR_TX, 8'h11, 1'b1);
        busWrite(ADDR_TX, 8'h22, 1'b1);
        in_data  = 8'h5A;
        in_valid = 1'b1;
        tick();
        rst_n = 1'b0;
        txQ.delete();
        #1;
        checkOutput("rst_out_valid", out_valid, 8'h00);
        checkOutput("rst_in_ready", in_ready, 8'h01);
        checkOutput("rst_rd_data", rd_data, 8'h00);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        busRead("rst_stat", ADDR_STAT, 8'h02);

        // Fill to full, overflow, then drain in order.
        $display("[TB] fill and overflow");
        busWrite(ADDR_TX, 8'h11, 1'b1);
        busWrite(ADDR_TX, 8'h22, 1'b1);
        busWrite(ADDR_TX, 8'h33, 1'b1);
        busWrite(ADDR_TX, 8'h44, 1'b1);
        busRead("full_stat", ADDR_STAT, 8'h01);
        busWrite(ADDR_TX, 8'h55, 1'b0);
        busRead("ovf_stat", ADDR_STAT, 8'h09);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_valid", out_valid, 8'h01);
            tick();
        end
        checkOutput("drain_done_valid", out_valid, 8'h00);
        checkOutput("drain_queue_left", 8'(txQ.size()), 8'h00);
        out_ready = 1'b0;

        // Push into a full FIFO while it pops: accepted, pointers wrap.
        $display("[TB] full with simultaneous pop");
        busWrite(ADDR_CTRL, 8'h01, 1'b0);
        busRead("clr_stat", ADDR_STAT, 8'h02);
        busWrite(ADDR_TX, 8'h11, 1'b1);
        busWrite(ADDR_TX, 8'h22, 1'b1);
        busWrite(ADDR_TX, 8'h33, 1'b1);
        busWrite(ADDR_TX, 8'h44, 1'b1);
        out_ready = 1'b1;
        busWrite(ADDR_TX, 8'h66, 1'b1);
        out_ready = 1'b0;
        busRead("pushpop_stat", ADDR_STAT, 8'h01);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("wrap_valid", out_valid, 8'h01);
            tick();
        end
        checkOutput("wrap_done_valid", out_valid, 8'h00);
        checkOutput("wrap_queue_left", 8'(txQ.size()), 8'h00);
        out_ready = 1'b0;

        // RX buffer fill, read, underflow, and read racing a new byte.
        $display("[TB] rx path");
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("rx_in_ready_low", in_ready, 8'h00);
        busRead("rx_read", ADDR_RX, 8'hA5);
        checkOutput("rx_in_ready_high", in_ready, 8'h01);
        busRead("rx_underflow_read", ADDR_RX, 8'h00);
        busRead("rx_underflow_stat", ADDR_STAT, 8'h12);
        in_data  = 8'h3C;
        in_valid = 1'b1;
        tick();
        in_data = 8'hC3;
        busRead("rx_race_read", ADDR_RX, 8'h3C);
        checkOutput("rx_race_ready", in_ready, 8'h01);
        tick();
        in_valid = 1'b0;
        checkOutput("rx_race_taken", in_ready, 8'h00);
        busRead("rx_second_read", ADDR_RX, 8'hC3);

        // CTRL clears flags and flushes queued bytes.
        $display("[TB] ctrl flush and clear");
        busWrite(ADDR_TX, 8'h77, 1'b1);
        busWrite(ADDR_TX, 8'h88, 1'b1);
        busRead("pre_flush_stat", ADDR_STAT, 8'h10);
        busWrite(ADDR_CTRL, 8'h03, 1'b0);
        txQ.delete();
        checkOutput("flush_out_valid", out_valid, 8'h00);
        busRead("flush_stat", ADDR_STAT, 8'h02);

        // Access outside the window: no hit, rd_data zero, nothing changes.
        $display("[TB] out-of-window access");
        addr = ADDR_RX;
        #1;
        checkOutput("hit_in_window", hit, 8'h01);
        addr    = 15'h0100;
        wr_data = 8'h99;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        #1;
        checkOutput("hit_outside", hit, 8'h00);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        checkOutput("miss_rd_data", rd_data, 8'h00);
        checkOutput("miss_out_valid", out_valid, 8'h00);
        busRead("miss_stat", ADDR_STAT, 8'h02);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
